// File: rtl/register_file.sv
// register_file: 32-entry architectural integer register file.
// Two combinational read ports with same-cycle write bypass, one write port
// committed on the rising clock edge, and a raw (unbypassed) debug read port.
// x0 is hardwired to zero; x2 resets to the initial stack pointer.
module register_file #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_REGS   = 32,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h0000_2ffc)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [4:0]            rd,
   input  logic [DATA_WIDTH-1:0] rd_din,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] rs1_dout,
   output logic [DATA_WIDTH-1:0] rs2_dout,
   input  logic [4:0]            dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_dout
);

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned SP_IDX  = 2;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic                  w_wr_ok;

   // A write (and therefore bypass) is only live while reset is released.
   assign w_wr_ok = write_enable & reset_n;

   // Array update: async reset to architectural reset values, x0 never written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
         end
      end else if (write_enable && (rd != ADDR_W'(0))) begin
         r_regs[rd] <= rd_din;
      end
   end

   // Read port 1: x0 forced to zero, otherwise bypass a matching write.
   always_comb begin
      rs1_dout = '0;
      if (rs1 != ADDR_W'(0)) begin
         if (w_wr_ok && (rd == rs1)) begin
            rs1_dout = rd_din;
         end else begin
            rs1_dout = r_regs[rs1];
         end
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      rs2_dout = '0;
      if (rs2 != ADDR_W'(0)) begin
         if (w_wr_ok && (rd == rs2)) begin
            rs2_dout = rd_din;
         end else begin
            rs2_dout = r_regs[rs2];
         end
      end
   end

   // Debug port: raw array contents, no bypass.
   always_comb begin
      dbg_dout = '0;
      if (dbg_addr != ADDR_W'(0)) begin
         dbg_dout = r_regs[dbg_addr];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard-driven bench for register_file.
module tb_register_file;

   localparam int unsigned DW      = 32;
   localparam logic [DW-1:0] SP_V  = 32'h0000_2ffc;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [4:0]    rs1 = '0;
   logic [4:0]    rs2 = '0;
   logic [4:0]    rd = '0;
   logic [DW-1:0] rd_din = '0;
   logic          write_enable = 1'b0;
   logic [DW-1:0] rs1_dout;
   logic [DW-1:0] rs2_dout;
   logic [4:0]    dbg_addr = '0;
   logic [DW-1:0] dbg_dout;

   logic [DW-1:0] m_regs [32];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_v;
   int            n_cmp = 0;
   int            n_err = 0;

   register_file #(.DATA_WIDTH(32), .NUM_REGS(32), .SP_INIT(SP_V)) dut (
      .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2), .rd(rd),
      .rd_din(rd_din), .write_enable(write_enable), .rs1_dout(rs1_dout),
      .rs2_dout(rs2_dout), .dbg_addr(dbg_addr), .dbg_dout(dbg_dout)
   );

   always #5 clk = ~clk;

   // Reference model reset values.
   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = (i == 2) ? SP_V : '0;
   endtask

   // Advance one rising edge, updating the model, then settle 1ns past it.
   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else if (write_enable && rd != 5'd0) m_regs[rd] = rd_din;
      #1;
   endtask

   // Expected read-port value from the model, bypass included.
   function automatic logic [DW-1:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return '0;
      if (write_enable && reset_n && rd == a) return rd_din;
      return m_regs[a];
   endfunction

   function automatic logic [DW-1:0] exp_dbg(input logic [4:0] a);
      return (a == 5'd0) ? '0 : m_regs[a];
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      write_enable = 1'b0;
      model_reset();
      repeat (3) step();
      rs1 = 5'd2; rs2 = 5'd9;
      exp_q.push_back(SP_V);
      exp_q.push_back('0);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL reset_rs1_x2 got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs2_dout !== exp_v) begin n_err++; $display("FAIL reset_rs2_x9 got %h exp %h", rs2_dout, exp_v); end
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         exp_q.push_back((i == 2) ? 32'h0000_2ffc : 32'h0);
         #1;
         exp_v = exp_q.pop_front(); n_cmp++;
         if (dbg_dout !== exp_v) begin n_err++; $display("FAIL reset_dbg x%0d got %h exp %h", i, dbg_dout, exp_v); end
      end
   endtask

   task automatic test_write_read();
      step();
      rd = 5'd5; rd_din = 32'hdead_beef; write_enable = 1'b1;
      step();
      write_enable = 1'b0; rs1 = 5'd5; rs2 = 5'd5; dbg_addr = 5'd5;
      exp_q.push_back(32'hdead_beef);
      exp_q.push_back(32'hdead_beef);
      exp_q.push_back(32'hdead_beef);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL wr_rd_rs1 got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs2_dout !== exp_v) begin n_err++; $display("FAIL wr_rd_rs2 got %h exp %h", rs2_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (dbg_dout !== exp_v) begin n_err++; $display("FAIL wr_rd_dbg got %h exp %h", dbg_dout, exp_v); end
      step();
   endtask

   task automatic test_bypass();
      rd = 5'd7; rd_din = 32'h1234; write_enable = 1'b1;
      rs1 = 5'd7; rs2 = 5'd6; dbg_addr = 5'd7;
      exp_q.push_back(32'h1234);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL bypass_rs1 got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs2_dout !== exp_v) begin n_err++; $display("FAIL bypass_rs2 got %h exp %h", rs2_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (dbg_dout !== exp_v) begin n_err++; $display("FAIL bypass_dbg_old got %h exp %h", dbg_dout, exp_v); end
      step();
      write_enable = 1'b0;
      exp_q.push_back(32'h1234);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (dbg_dout !== exp_v) begin n_err++; $display("FAIL bypass_dbg_new got %h exp %h", dbg_dout, exp_v); end
      step();
   endtask

   task automatic test_x0();
      rd = 5'd0; rd_din = 32'hffff_ffff; write_enable = 1'b1;
      rs1 = 5'd0; dbg_addr = 5'd0;
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL x0_write_cycle got %h exp %h", rs1_dout, exp_v); end
      step();
      write_enable = 1'b0;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL x0_after_edge got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (dbg_dout !== exp_v) begin n_err++; $display("FAIL x0_dbg got %h exp %h", dbg_dout, exp_v); end
      step();
   endtask

   task automatic test_async_reset();
      rd = 5'd3; rd_din = 32'h55; write_enable = 1'b1;
      step();
      rd = 5'd2; rd_din = 32'h99;
      step();
      rd = 5'd3; rd_din = 32'h77; rs1 = 5'd3; rs2 = 5'd2; dbg_addr = 5'd3;
      exp_q.push_back(32'h77);
      exp_q.push_back(32'h99);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL arst_pre_rs1 got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs2_dout !== exp_v) begin n_err++; $display("FAIL arst_pre_rs2 got %h exp %h", rs2_dout, exp_v); end
      reset_n = 1'b0;
      model_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(SP_V);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs1_dout !== exp_v) begin n_err++; $display("FAIL arst_rs1_x3 got %h exp %h", rs1_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (rs2_dout !== exp_v) begin n_err++; $display("FAIL arst_rs2_x2 got %h exp %h", rs2_dout, exp_v); end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (dbg_dout !== exp_v) begin n_err++; $display("FAIL arst_dbg_x3 got %h exp %h", dbg_dout, exp_v); end
      write_enable = 1'b0;
      #1 reset_n = 1'b1;
      step();
   endtask

   task automatic test_dual_port();
      logic [DW-1:0] e1, e2, ed;
      for (int i = 1; i < 32; i++) begin
         rd = 5'(i); rd_din = 32'h100 + 32'(i); write_enable = 1'b1;
         step();
      end
      for (int c = 0; c < 200; c++) begin
         rs1 = 5'($urandom_range(0, 31));
         rs2 = ((c % 5) == 0) ? rs1 : 5'($urandom_range(0, 31));
         rd = ((c % 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
         rd_din = $urandom;
         write_enable = 1'($urandom_range(0, 1));
         dbg_addr = 5'($urandom_range(0, 31));
         exp_q.push_back(exp_rd(rs1));
         exp_q.push_back(exp_rd(rs2));
         exp_q.push_back(exp_dbg(dbg_addr));
         #1;
         e1 = exp_q.pop_front(); e2 = exp_q.pop_front(); ed = exp_q.pop_front();
         n_cmp++;
         if (rs1_dout !== e1) begin n_err++; $display("FAIL dual_rs1 cyc %0d rs1=%0d got %h exp %h", c, rs1, rs1_dout, e1); end
         n_cmp++;
         if (rs2_dout !== e2) begin n_err++; $display("FAIL dual_rs2 cyc %0d rs2=%0d got %h exp %h", c, rs2, rs2_dout, e2); end
         n_cmp++;
         if (dbg_dout !== ed) begin n_err++; $display("FAIL dual_dbg cyc %0d dbg=%0d got %h exp %h", c, dbg_addr, dbg_dout, ed); end
         step();
      end
      write_enable = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_write_read();
      test_bypass();
      test_x0();
      test_async_reset();
      test_dual_port();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
